// File: rtl/coin_credit_accumulator.sv
// coin_credit_accumulator: coin credit front end feeding the vending FSM (optional COIN_REJECT_EN adds coin_reject)
module coin_credit_accumulator #(
  parameter int CREDIT_W    = 64,
  parameter int TIMEOUT_CYC = 1000,
  parameter int TMR_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                product_sel,
  input  logic [CREDIT_W-1:0] price_a,
  input  logic [CREDIT_W-1:0] price_b,
  input  logic                cancel,
  input  logic                vend_ack,
  input  logic                refund_ack,
  output logic                condition,
  output logic                sel,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend_req,
  output logic                refund_valid,
  output logic [CREDIT_W-1:0] refund_amount,
`ifdef COIN_REJECT_EN
  output logic                coin_reject,
`endif
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;
  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, refund_amount_q, refund_amount_d;
  logic [CREDIT_W-1:0] coin_val, price, add, rem;
  logic [CREDIT_W:0]   sum;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                sel_q, sel_d, condition_q, condition_d, vend_req_q, vend_req_d;
  logic                refund_valid_q, refund_valid_d, busy_q, busy_d, timeout;
  assign coin_val = coin_type == 2'd0 ? CREDIT_W'(5) :
                    coin_type == 2'd1 ? CREDIT_W'(10) :
                    coin_type == 2'd2 ? CREDIT_W'(25) : CREDIT_W'(100);
  assign price    = sel_q ? price_a : price_b;
  assign sum      = {1'b0, credit_q} + {1'b0, coin_val};
  assign add      = !coin_valid ? credit_q : sum[CREDIT_W] ? '1 : sum[CREDIT_W-1:0];
  assign rem      = credit_q - price;
  assign timeout  = !coin_valid && timer_q == TMR_W'(TIMEOUT_CYC - 1);
  // next-state and registered-output logic; condition tracks next credit against next price
  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    sel_d           = sel_q;
    timer_d         = timer_q;
    vend_req_d      = vend_req_q;
    refund_valid_d  = refund_valid_q;
    refund_amount_d = refund_amount_q;
    case (state_q)
      IDLE: if (coin_valid) begin
        state_d  = COLLECT;
        credit_d = coin_val;
        sel_d    = product_sel;
        timer_d  = '0;
      end
      COLLECT: begin
        credit_d = add;
        timer_d  = coin_valid ? '0 : cancel ? timer_q : timer_q + TMR_W'(1);
        if (cancel || timeout) begin
          state_d         = REFUND;
          refund_valid_d  = 1'b1;
          refund_amount_d = add;
        end else if (add >= price) begin
          state_d    = VEND;
          vend_req_d = 1'b1;
        end
      end
      VEND: if (vend_ack && vend_req_q) begin
        vend_req_d = 1'b0;
        credit_d   = rem;
        if (rem != '0) begin
          state_d         = REFUND;
          refund_valid_d  = 1'b1;
          refund_amount_d = rem;
        end else begin
          state_d = IDLE;
          sel_d   = 1'b0;
        end
      end
      REFUND: if (refund_ack && refund_valid_q) begin
        state_d         = IDLE;
        credit_d        = '0;
        sel_d           = 1'b0;
        refund_valid_d  = 1'b0;
        refund_amount_d = '0;
      end
      default: state_d = IDLE;
    endcase
    condition_d = credit_d >= (sel_d ? price_a : price_b);
    busy_d      = state_d != IDLE;
  end
  // state and output registers; reset drops credit without any refund request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      credit_q        <= '0;
      sel_q           <= 1'b0;
      timer_q         <= '0;
      condition_q     <= 1'b0;
      vend_req_q      <= 1'b0;
      refund_valid_q  <= 1'b0;
      refund_amount_q <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      sel_q           <= sel_d;
      timer_q         <= timer_d;
      condition_q     <= condition_d;
      vend_req_q      <= vend_req_d;
      refund_valid_q  <= refund_valid_d;
      refund_amount_q <= refund_amount_d;
      busy_q          <= busy_d;
    end
  end
`ifdef COIN_REJECT_EN
  logic coin_reject_q;
  // flag a coin that arrived while a vend or refund was in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) coin_reject_q <= 1'b0;
    else coin_reject_q <= coin_valid && (state_q == VEND || state_q == REFUND);
  end
  assign coin_reject = coin_reject_q;
`endif
  assign condition     = condition_q;
  assign sel           = sel_q;
  assign credit        = credit_q;
  assign vend_req      = vend_req_q;
  assign refund_valid  = refund_valid_q;
  assign refund_amount = refund_amount_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_coin_credit_accumulator.sv
// tb_coin_credit_accumulator: scoreboard bench for coin_credit_accumulator
module tb_coin_credit_accumulator;
  localparam int CW = 8;
  logic clk = 0, reset = 1, coin_valid = 0, product_sel = 0, cancel = 0, vend_ack = 0, refund_ack = 0;
  logic [1:0] coin_type = 0;
  logic [CW-1:0] price_a = 110, price_b = 150;
  logic condition, sel, vend_req, refund_valid, busy;
  logic [CW-1:0] credit, refund_amount;
`ifdef COIN_REJECT_EN
  logic coin_reject;
  int rej_cnt = 0;
`endif
  int errors = 0, checks = 0, vr_rises = 0, rv_rises = 0;
  logic vr_prev = 0, rv_prev = 0;
  logic [CW-1:0] exp_vend[$], exp_refund[$];
  coin_credit_accumulator #(.CREDIT_W(CW), .TIMEOUT_CYC(8), .TMR_W(8)) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type),
    .product_sel(product_sel), .price_a(price_a), .price_b(price_b), .cancel(cancel),
    .vend_ack(vend_ack), .refund_ack(refund_ack), .condition(condition), .sel(sel),
    .credit(credit), .vend_req(vend_req), .refund_valid(refund_valid),
    .refund_amount(refund_amount),
`ifdef COIN_REJECT_EN
    .coin_reject(coin_reject),
`endif
    .busy(busy));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic coin(input logic [1:0] t);
    @(negedge clk);
    coin_valid = 1;
    coin_type = t;
    @(negedge clk);
    coin_valid = 0;
  endtask
  task automatic pulse_vack();
    @(negedge clk);
    vend_ack = 1;
    @(negedge clk);
    vend_ack = 0;
  endtask
  task automatic pulse_rack();
    @(negedge clk);
    refund_ack = 1;
    @(negedge clk);
    refund_ack = 0;
  endtask
  task automatic wait_hi(input string tag, input bit refund);
    for (int i = 0; i < 20; i++) begin
      if (refund ? refund_valid : vend_req) return;
      @(negedge clk);
    end
    chk(tag, 0, 1);
  endtask
  // scoreboard: compare DUT handshake launches with queued expectations
  always @(negedge clk) begin
    if (!reset) begin
      if (vend_req || refund_valid) chk("exclusive", vend_req & refund_valid, 0);
      if (vend_req && !vr_prev) begin
        vr_rises++;
        if (exp_vend.size() == 0) chk("vend_unexpected", 1, 0);
        else chk("vend_credit", credit, exp_vend.pop_front());
        chk("vend_condition", condition, 1);
      end
      if (refund_valid && !rv_prev) begin
        rv_rises++;
        if (exp_refund.size() == 0) chk("refund_unexpected", 1, 0);
        else chk("refund_amount", refund_amount, exp_refund.pop_front());
      end
`ifdef COIN_REJECT_EN
      if (coin_reject) rej_cnt++;
`endif
    end
    vr_prev <= vend_req;
    rv_prev <= refund_valid;
  end
  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_credit", credit, 0);
    chk("rst_cond", condition, 0);
    chk("rst_sel", sel, 0);
    chk("rst_vreq", vend_req, 0);
    chk("rst_rvalid", refund_valid, 0);
    chk("rst_ramt", refund_amount, 0);
    reset = 0;
    // exact pay
    exp_vend.push_back(150);
    coin(3);
    chk("t1_credit1", credit, 100);
    chk("t1_busy", busy, 1);
    chk("t1_cond1", condition, 0);
    coin(2);
    chk("t1_credit2", credit, 125);
    coin(2);
    wait_hi("t1_vend_timeout", 0);
    chk("t1_cond3", condition, 1);
    pulse_vack();
    #1;
    chk("t1_idle", busy, 0);
    chk("t1_credit0", credit, 0);
    chk("t1_vreq_drop", vend_req, 0);
    chk("t1_no_refund", rv_rises, 0);
    // overpay on tier A
    product_sel = 1;
    exp_vend.push_back(125);
    exp_refund.push_back(15);
    coin(3);
    chk("t2_sel", sel, 1);
    product_sel = 0;
    coin(2);
    wait_hi("t2_vend_timeout", 0);
    chk("t2_credit", credit, 125);
    pulse_vack();
    wait_hi("t2_refund_timeout", 1);
    chk("t2_ramt", refund_amount, 15);
    pulse_rack();
    chk("t2_idle", busy, 0);
    chk("t2_credit0", credit, 0);
    chk("t2_ramt0", refund_amount, 0);
    chk("t2_rvalid0", refund_valid, 0);
    chk("t2_sel0", sel, 0);
    // cancel with a same-cycle coin
    exp_refund.push_back(40);
    coin(2);
    coin(1);
    @(negedge clk);
    coin_valid = 1;
    coin_type = 0;
    cancel = 1;
    @(negedge clk);
    coin_valid = 0;
    cancel = 0;
    chk("t3_rvalid", refund_valid, 1);
    chk("t3_ramt", refund_amount, 40);
    chk("t3_no_vend", vr_rises, 2);
    pulse_rack();
    chk("t3_idle", busy, 0);
    // inactivity timeout
    exp_refund.push_back(10);
    coin(1);
    n = 0;
    for (int i = 0; i < 20 && !refund_valid; i++) begin
      @(negedge clk);
      n++;
    end
    chk("t4_idle_cycles", n, 8);
    chk("t4_ramt", refund_amount, 10);
    chk("t4_no_vend", vr_rises, 2);
    pulse_rack();
    // saturation, uncredited coin during VEND, async reset
    price_b = 255;
    exp_vend.push_back(255);
    coin(3);
    coin(3);
    chk("t5_credit200", credit, 200);
    coin(3);
    wait_hi("t5_vend_timeout", 0);
    chk("t5_sat", credit, 255);
    coin(3);
    chk("t5_nocredit", credit, 255);
    chk("t5_vreq_held", vend_req, 1);
    repeat (3) @(negedge clk);
`ifdef COIN_REJECT_EN
    chk("t5_reject_once", rej_cnt, 1);
`endif
    #2 reset = 1;
    #1;
    chk("t5_rst_vreq", vend_req, 0);
    chk("t5_rst_credit", credit, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_cond", condition, 0);
    chk("t5_rst_rvalid", refund_valid, 0);
    @(negedge clk);
    chk("vend_queue_empty", exp_vend.size(), 0);
    chk("refund_queue_empty", exp_refund.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/coin_credit_accumulator.md
Name: coin_credit_accumulator

Overview:
- Upstream front end of the vending FSM. Accepts coin events and a product select, then accumulates credit against a price.
- Produces the vending FSM's `condition` (credit covers price) and `sel` (product tier) inputs.
- Runs the vend-request / refund handshakes with the dispenser and the coin return.

Parameters:
- CREDIT_W, 64, width of credit, price and refund datapath.
- TIMEOUT_CYC, 1000, idle cycles in COLLECT (no coin, no cancel) before auto-refund; must be >= 2.
- TMR_W, 16, timeout counter width; must hold TIMEOUT_CYC.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- coin_valid  input  1  one-cycle coin event.
- coin_type  input  2  0=5, 1=10, 2=25, 3=100 credit units; sampled with coin_valid.
- product_sel  input  1  product tier; latched on the first accepted coin.
- price_a  input  CREDIT_W  price when latched sel=1.
- price_b  input  CREDIT_W  price when latched sel=0.
- cancel  input  1  customer cancel, level-sampled.
- vend_ack  input  1  dispenser accepted the vend.
- refund_ack  input  1  coin return paid refund_amount.
- condition  output  1  registered; 1 when credit >= selected price.
- sel  output  1  latched product tier.
- credit  output  CREDIT_W  current credit.
- vend_req  output  1  vend request, held until acknowledged.
- refund_valid  output  1  refund request, held until acknowledged.
- refund_amount  output  CREDIT_W  amount to return; stable while refund_valid=1.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async): state=IDLE. credit, refund_amount and the timer are 0. condition, sel, vend_req, refund_valid and busy are 0.
- States (registered): IDLE, COLLECT, VEND, REFUND. All outputs are registered.
- price = sel ? price_a : price_b, using the latched sel. Prices are sampled each cycle and must be stable while busy=1.
- IDLE:
  - coin_valid -> credit=coin value, sel=product_sel, timer=0, next state COLLECT.
  - cancel is ignored.
- COLLECT:
  - Each coin adds its value to credit; the sum saturates at 2^CREDIT_W-1 (no wrap). Timer clears on every coin.
  - The timer increments on cycles with no coin and no cancel.
  - Priority, evaluated on the post-add credit:
    - cancel -> REFUND.
    - else timer==TIMEOUT_CYC-1 -> REFUND.
    - else credit>=price -> VEND.
  - A coin arriving in the same cycle as cancel is added before the refund.
- VEND:
  - vend_req=1 in the cycle after entry, held until vend_ack is sampled high.
  - On vend_ack: credit -= price. If the remainder > 0, go to REFUND; else go to IDLE with credit=0, sel=0.
  - cancel is ignored in VEND.
- REFUND:
  - On entry, refund_amount=credit and refund_valid=1.
  - On refund_ack: credit=0, refund_valid=0, refund_amount=0, sel=0, go to IDLE.
- Coins in VEND or REFUND are not credited.
- condition is updated every cycle from the next-state credit and price, so it reflects the credit visible on the same cycle.
- vend_req and refund_valid are never high together.
- An ack received when no request is outstanding is ignored.
- Reset asserted mid-transaction discards credit without a refund pulse.

Optional Feature:
- Macro COIN_REJECT_EN.
- Defined: adds output port coin_reject (1 bit, reset 0). It pulses high for one cycle, one cycle after any coin_valid that was not credited (state VEND or REFUND).
- Undefined: the port is absent and uncredited coins are dropped silently.
- Core behaviour is identical either way.

Test Plan:
- Exact pay, price_b=150, product_sel=0: coins 100,25,25 -> condition=1 and vend_req=1 after the third coin; vend_ack -> IDLE, credit=0, no refund.
- Overpay, price_a=110, product_sel=1: coins 100,25 -> sel=1, credit=125, vend; vend_ack -> refund_valid=1, refund_amount=15; refund_ack -> IDLE.
- Cancel, price 150: coins 25,10, then cancel together with coin 5 -> refund_amount=40, no vend_req.
- Timeout, TIMEOUT_CYC=8: single coin 10, then idle -> refund_valid asserts after 8 idle cycles with refund_amount=10.
- Coin during VEND with vend_ack delayed 5 cycles: credit unchanged and coin_reject pulses once (with COIN_REJECT_EN).
- Saturation and reset: credit preset near max by 4 coins of 100 with CREDIT_W=8 -> credit saturates at 255 and does not wrap; async reset mid-VEND clears all outputs immediately.
